// File: rtl/counter_run_arbiter.sv
// Round-robin owner of a single run-length counter: grants one requester,
// counts 0..limit (or until abort), pulses done, then rotates priority.
module counter_run_arbiter #(
    parameter int BITS = 8,
    parameter int NREQ = 4,
    parameter int OW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] len,
    input  logic                 abort,
    output logic [NREQ-1:0]      grant,
    output logic [OW-1:0]        owner,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [BITS-1:0]      count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [BITS-1:0] limit_q, limit_d;
    logic [BITS-1:0] count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;

    logic [BITS-1:0] len_arr [NREQ];
    logic [OW-1:0]   cand;
    logic [OW-1:0]   pick_idx;
    logic            pick_valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
            assign len_arr[gi] = len[gi*BITS +: BITS];
        end
    endgenerate

    // Scan offsets from the far end down so the nearest requester after
    // last_q is the final (winning) assignment; OW-bit wrap gives the modulo.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = last_q + OW'(i) + OW'(1);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        limit_d   = limit_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_RUN;
                    owner_d = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    limit_d = len_arr[pick_idx];
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over the terminal check and freezes the count.
                if (abort) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (count_q == limit_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + BITS'(1);
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                grant_d   = '0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                aborted_d = 1'b0;
                last_d    = owner_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= OW'(NREQ - 1);
            limit_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign count   = count_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Bench for counter_run_arbiter: scenario tasks with inline timing checks and
// a done-pulse scoreboard holding the expected owner/count/aborted per run.
module tb_counter_run_arbiter;

    localparam int BITS = 8;
    localparam int NREQ = 4;
    localparam int OW   = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] len;
    logic                 abort;
    logic [NREQ-1:0]      grant;
    logic [OW-1:0]        owner;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [BITS-1:0]      count;

    typedef struct {
        int owner;
        int count;
        int aborted;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    counter_run_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .len     (len),
        .abort   (abort),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest expected run.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: owner=%0d count=%0d, no run expected", owner, count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(owner) !== e.owner || int'(count) !== e.count || int'(aborted) !== e.aborted) begin
                    n_fail++;
                    $display("FAIL sb_done: got owner=%0d count=%0d aborted=%0d, want owner=%0d count=%0d aborted=%0d",
                             owner, count, aborted, e.owner, e.count, e.aborted);
                end else begin
                    $display("done: owner=%0d count=%0d aborted=%0d", owner, count, aborted);
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        abort = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
            count !== 8'd0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_vals: grant=%b busy=%b done=%b aborted=%b count=%0d owner=%0d, want all zero",
                     grant, busy, done, aborted, count, owner);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_run();
        int busy_cycles;
        len[2*BITS +: BITS] = 8'd5;
        req = 4'b0100;
        exp_q.push_back('{2, 5, 0});
        tick();
        req = 4'b0000;
        busy_cycles = 0;
        n_checks++;
        if (grant !== 4'b0100 || owner !== 2'd2 || count !== 8'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b owner=%0d count=%0d busy=%b, want 0100/2/0/1", grant, owner, count, busy);
        end
        if (busy === 1'b1) busy_cycles++;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            n_checks++;
            if (count !== 8'(k) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_count: count=%0d done=%b, want %0d/0", count, done, k);
            end
        end
        tick();
        if (busy === 1'b1) busy_cycles++;
        n_checks++;
        if (done !== 1'b1 || grant !== 4'b0100 || count !== 8'd5) begin
            n_fail++;
            $display("FAIL single_done: done=%b grant=%b count=%0d, want 1/0100/5", done, grant, count);
        end
        tick();
        if (busy === 1'b1) busy_cycles++;
        n_checks++;
        if (grant !== 4'b0000 || done !== 1'b0 || busy_cycles != 7) begin
            n_fail++;
            $display("FAIL single_end: grant=%b done=%b busy_cycles=%0d, want 0000/0/7", grant, done, busy_cycles);
        end
        $display("single_run: len=5 owner=2 busy_cycles=%0d", busy_cycles);
    endtask

    task automatic test_round_robin();
        int dones;
        int prev;
        apply_reset();
        for (int i = 0; i < NREQ; i++) len[i*BITS +: BITS] = 8'd2;
        exp_q.push_back('{0, 2, 0});
        exp_q.push_back('{1, 2, 0});
        exp_q.push_back('{2, 2, 0});
        exp_q.push_back('{3, 2, 0});
        exp_q.push_back('{0, 2, 0});
        req   = 4'b1111;
        dones = 0;
        prev  = 0;
        for (int cyc = 1; cyc <= 60 && dones < 5; cyc++) begin
            tick();
            if (done === 1'b1) begin
                dones++;
                if (dones > 1) begin
                    n_checks++;
                    if (cyc - prev != 5) begin
                        n_fail++;
                        $display("FAIL rr_spacing: done gap=%0d cycles, want 5", cyc - prev);
                    end
                end
                prev = cyc;
                if (dones == 5) req = 4'b0000;
            end
        end
        n_checks++;
        if (dones != 5) begin
            n_fail++;
            $display("FAIL rr_timeout: saw %0d done pulses, want 5", dones);
        end
        tick();
        tick();
        $display("round_robin: %0d done pulses", dones);
    endtask

    task automatic test_zero_len();
        len[0 +: BITS] = 8'd0;
        req = 4'b0001;
        exp_q.push_back('{0, 0, 0});
        tick();
        req = 4'b0000;
        n_checks++;
        if (grant !== 4'b0001 || count !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_run: grant=%b count=%0d busy=%b done=%b, want 0001/0/1/0", grant, count, busy, done);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: done=%b busy=%b, want 1/1", done, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_idle: busy=%b grant=%b, want 0/0000", busy, grant);
        end
        $display("zero_len: run checked");
    endtask

    task automatic test_abort();
        len[1*BITS +: BITS] = 8'd200;
        req = 4'b0010;
        exp_q.push_back('{1, 10, 1});
        tick();
        req = 4'b0000;
        for (int k = 0; k < 10; k++) tick();
        n_checks++;
        if (count !== 8'd10 || grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_pre: count=%0d grant=%b, want 10/0010", count, grant);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b1 || aborted !== 1'b1 || count !== 8'd10) begin
            n_fail++;
            $display("FAIL abort_done: done=%b aborted=%b count=%0d, want 1/1/10", done, aborted, count);
        end
        tick();
        abort = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || grant !== 4'b0000 || count !== 8'd10) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b done=%b aborted=%b grant=%b count=%0d, want 0/0/0/0000/10",
                     busy, done, aborted, grant, count);
        end
        abort = 1'b0;
        $display("abort: frozen at count=%0d", count);
    endtask

    task automatic test_reset_midrun();
        bit seen;
        len[2*BITS +: BITS] = 8'd20;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (count !== 8'd7) begin
            n_fail++;
            $display("FAIL midrun_count: count=%0d, want 7", count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
            count !== 8'd0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: grant=%b busy=%b done=%b aborted=%b count=%0d owner=%0d, want all zero",
                     grant, busy, done, aborted, count, owner);
        end
        len[3*BITS +: BITS] = 8'd3;
        req = 4'b1000;
        exp_q.push_back('{3, 3, 0});
        tick();
        req = 4'b0000;
        n_checks++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            n_fail++;
            $display("FAIL midrun_regrant: grant=%b owner=%0d, want 1000/3", grant, owner);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midrun_timeout: no done for requester 3");
        end
        tick();
        $display("reset_midrun: regrant to 3 checked");
    endtask

    task automatic test_captured_len();
        len[0 +: BITS] = 8'd4;
        req = 4'b0001;
        exp_q.push_back('{0, 4, 0});
        tick();
        req = 4'b0000;
        len[0 +: BITS] = 8'd1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (count !== 8'(k) || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL captured_count: count=%0d done=%b busy=%b, want %0d/0/1", count, done, busy, k);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL captured_done: done=%b, want 1", done);
        end
        tick();
        $display("captured_len: run held limit 4");
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        len   = '0;
        abort = 1'b0;
        test_reset();
        test_single_run();
        test_round_robin();
        test_zero_len();
        test_abort();
        test_reset_midrun();
        test_captured_len();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected runs never completed, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_run_arbiter.md
# counter_run_arbiter

Round-robin scheduler that shares one run-length counter between `NREQ` requesters in the user project area. Each requester asks for a counting run of a given length. The block grants one requester at a time, sequences the counter from zero to the requested length, and signals completion. It sits between the pad-level request inputs and the count outputs driven onto the user GPIO pads.

## Interface

**Parameters**
- `BITS`, 8: counter and length width.
- `NREQ`, 4: number of requesters; must be a power of two, at least 2.
- `OW`, `$clog2(NREQ)`: owner index width (derived; do not override).

**Ports**
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NREQ  per-requester run request; level.
- `len`  in  NREQ*BITS  run lengths; requester i uses `len[i*BITS +: BITS]`.
- `abort`  in  1  terminates the active run early.
- `grant`  out  NREQ  one-hot grant to the current owner; zero when idle.
- `owner`  out  OW  index of the current or last owner.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: run ended by `abort`.
- `count`  out  BITS  counter value.

## Operation

- States:
  - IDLE: no grant.
  - RUN: counting.
  - DONE: one-cycle completion.
- Reset values:
  - state = IDLE
  - `grant` = 0, `busy` = 0, `done` = 0, `aborted` = 0
  - `count` = 0, `owner` = 0
  - internal `last` = NREQ-1, so requester 0 has first priority.
- IDLE, when any `req` bit is high:
  - Select the first set bit, scanning from (`last`+1) mod NREQ upward with wrap.
  - Register `owner` and the one-hot `grant`.
  - Capture the owner's `len` slice into `limit`; set `count` = 0; go to RUN.
  - No requests: stay in IDLE; `count` holds its value.
- RUN:
  - `len` and `req` are ignored; the captured `limit` is used and dropping `req` does not end the run.
  - `count` < `limit`: increment `count` by 1.
  - `count` == `limit`: go to DONE. This check also covers `limit` = 0, which therefore spends one cycle in RUN.
  - `abort` high: go to DONE with `aborted` = 1; `count` freezes and does not increment that cycle. `abort` takes priority over the terminal check.
  - `count` never wraps, since `limit` ≤ 2^BITS-1.
- DONE:
  - `done` = 1 for exactly one cycle; `grant` is still held.
  - Set `last` = `owner`; go to IDLE.
- Leaving DONE for IDLE:
  - Clear `grant`, `done` and `aborted`.
  - `count` and `owner` hold until the next grant.
- `abort` outside RUN has no effect.
- Reset is honoured in any state, including mid-run. All outputs return to their reset values on the next edge. An in-flight run is discarded without a `done` pulse.

## Timing

- All outputs are registered.
- Taking edge t as the one where IDLE samples `req`:
  - `grant`, `busy` and `owner` are valid after edge t; `count` = 0.
  - `count` = k after edge t+k, for k ≤ `limit`.
  - DONE (`done` = 1) after edge t+`limit`+1.
  - IDLE after edge t+`limit`+2.
  - The earliest next grant is after edge t+`limit`+3.
- Run occupancy: `limit`+2 cycles of `busy`, plus one mandatory IDLE gap between runs.
- Abort sampled at edge a in RUN: `done` = 1 and `aborted` = 1 after edge a.
- Simultaneous requests: resolved only in IDLE, by round-robin. A requester holding `req` continuously gets the lowest priority after its own run, so there is no starvation. With all NREQ requesting, the service order is 0, 1, …, NREQ-1, 0, …

## Test plan

1. Reset, then `req` = 4'b0100 with `len[2]` = 5 → `grant` = 4'b0100 and `owner` = 2. `count` steps 0..5 over 6 cycles, then `done` = 1 for one cycle with `aborted` = 0, then `grant` = 0. `busy` is high for 7 cycles.
2. `req` = 4'b1111 held, all `len` = 2 → owners are served in order 0, 1, 2, 3, 0. Each pair of `done` pulses is 5 cycles apart.
3. `len[0]` = 0, `req[0]` pulsed → `count` = 0 for one RUN cycle, then a `done` pulse; `busy` is high for 2 cycles.
4. `len[1]` = 200 with `abort` high when `count` = 10 → `count` freezes at 10 with `done` = 1 and `aborted` = 1 the next cycle, then IDLE. A later `abort` while IDLE has no effect.
5. `reset` asserted at `count` = 7 mid-run → all outputs return to reset values on the next edge with no `done` pulse. A new `req[3]` is then granted to requester 3; with only `req[3]` set, the reset priority still grants it.
6. `req[0]` dropped and `len[0]` changed during RUN → the run completes to the originally captured `limit`.
